// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer:
// selection-mode encodings and the wrapped channel-index helper.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index reached by stepping off places past base, wrapping at n.
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin search: finds the first requesting channel
// after the last-granted one, wrapping modulo NCH.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] last,
    output logic [SELW-1:0] chosen,
    output logic            found
);

    logic [SELW-1:0] idx;

    always_comb begin
        chosen = '0;
        found  = 1'b0;
        idx    = '0;
        // Offset NCH lands back on last itself, so it is searched at lowest priority.
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = SELW'(wrap_idx(32'(last), i, NCH));
            if (!found && req[idx]) begin
                found  = 1'b1;
                chosen = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin
// selection and a single registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [NCH*W-1:0]  ic,
    input  logic [NCH-1:0]    ivalid,
    output logic [NCH-1:0]    oready,
    input  logic              imode,
    input  logic [SELW-1:0]   isel,
    output logic [W-1:0]      oz,
    output logic              ovalid,
    input  logic              iready,
    output logic [SELW-1:0]   ogrant
);

    localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

    logic [W-1:0]    oz_q;
    logic            ovalid_q;
    logic [SELW-1:0] ogrant_q;
    logic [SELW-1:0] last_q;

    logic [SELW-1:0] arb_chosen;
    logic            arb_found;
    logic [SELW-1:0] chosen;
    logic            have;
    logic            load;
    logic            grant_en;
    logic            xfer;
    logic [W-1:0]    din;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req    (ivalid),
        .last   (last_q),
        .chosen (arb_chosen),
        .found  (arb_found)
    );

    assign load = ~ovalid_q | iready;

    always_comb begin
        chosen   = '0;
        have     = 1'b0;
        grant_en = 1'b0;
        oready   = '0;
        din      = '0;
        if (imode == MODE_RR) begin
            chosen = arb_chosen;
            have   = arb_found;
        end else begin
            chosen = isel;
            have   = ({1'b0, isel} < NCH_W);
        end
        // Fixed mode never looks at ivalid here, so oready cannot loop back through it.
        grant_en = have & load & ~irst;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (chosen == SELW'(k)) begin
                oready[k] = grant_en;
                din       = ic[k*W +: W];
            end
        end
        xfer = |(ivalid & oready);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            oz_q     <= '0;
            ovalid_q <= 1'b0;
            ogrant_q <= '0;
            last_q   <= SELW'(NCH - 1);
        end else if (xfer) begin
            oz_q     <= din;
            ogrant_q <= chosen;
            ovalid_q <= 1'b1;
            if (imode == MODE_RR) begin
                last_q <= chosen;
            end
        end else if (load) begin
            ovalid_q <= 1'b0;
        end
    end

    assign oz     = oz_q;
    assign ovalid = ovalid_q;
    assign ogrant = ogrant_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr with NCH=4, W=4.
module tb_stream_mux_rr;

    localparam int unsigned NCH  = 4;
    localparam int unsigned W    = 4;
    localparam int unsigned SELW = 2;

    logic             iclk;
    logic             irst;
    logic [NCH*W-1:0] ic;
    logic [NCH-1:0]   ivalid;
    logic [NCH-1:0]   oready;
    logic             imode;
    logic [SELW-1:0]  isel;
    logic [W-1:0]     oz;
    logic             ovalid;
    logic             iready;
    logic [SELW-1:0]  ogrant;

    int checks = 0;
    int errors = 0;

    stream_mux_rr #(
        .NCH (NCH),
        .W   (W)
    ) dut (
        .iclk   (iclk),
        .irst   (irst),
        .ic     (ic),
        .ivalid (ivalid),
        .oready (oready),
        .imode  (imode),
        .isel   (isel),
        .oz     (oz),
        .ovalid (ovalid),
        .iready (iready),
        .ogrant (ogrant)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        irst   = 1'b1;
        ivalid = '0;
        iready = 1'b1;
        imode  = 1'b1;
        isel   = '0;
        step();
        irst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        irst   = 1'b1;
        ivalid = 4'b1111;
        imode  = 1'b1;
        iready = 1'b1;
        isel   = '0;
        step();
        #1;
        checks++;
        if (oready !== 4'b0000) begin
            errors++; $display("FAIL reset_oready: got %b want %b", oready, 4'b0000);
        end
        step();
        checks++;
        if (ovalid !== 1'b0 || oz !== 4'h0 || ogrant !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ovalid=%b oz=%h ogrant=%0d want 0 0 0",
                     ovalid, oz, ogrant);
        end
        irst = 1'b0;
        #1;
        checks++;
        if (oready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_ready: got %b want %b", oready, 4'b0001);
        end
        step();
        checks++;
        if (ovalid !== 1'b1 || ogrant !== 2'd0 || oz !== 4'hA) begin
            errors++;
            $display("FAIL reset_first_grant: got ovalid=%b ogrant=%0d oz=%h want 1 0 a",
                     ovalid, ogrant, oz);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        imode  = 1'b0;
        isel   = 2'd2;
        ivalid = 4'b0100;
        iready = 1'b1;
        #1;
        checks++;
        if (oready !== 4'b0100) begin
            errors++; $display("FAIL fixed_oready: got %b want %b", oready, 4'b0100);
        end
        step();
        checks++;
        if (oz !== 4'hC || ovalid !== 1'b1 || ogrant !== 2'd2) begin
            errors++;
            $display("FAIL fixed_output: got oz=%h ovalid=%b ogrant=%0d want c 1 2",
                     oz, ovalid, ogrant);
        end
        // Fixed-mode ready must not depend on the selected channel's valid.
        ivalid = 4'b0000;
        #1;
        checks++;
        if (oready !== 4'b0100) begin
            errors++; $display("FAIL fixed_ready_novalid: got %b want %b", oready, 4'b0100);
        end
        step();
        checks++;
        if (ovalid !== 1'b0 || oz !== 4'hC || ogrant !== 2'd2) begin
            errors++;
            $display("FAIL fixed_drain: got ovalid=%b oz=%h ogrant=%0d want 0 c 2",
                     ovalid, oz, ogrant);
        end
    endtask

    task automatic test_rr_fair();
        logic [W-1:0] exp_oz;
        do_reset();
        imode  = 1'b1;
        ivalid = 4'b1111;
        iready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_oz = 4'hA + 4'(i % 4);
            checks++;
            if (ogrant !== 2'(i % 4) || ovalid !== 1'b1 || oz !== exp_oz) begin
                errors++;
                $display("FAIL rr_fair[%0d]: got ogrant=%0d ovalid=%b oz=%h want %0d 1 %h",
                         i, ogrant, ovalid, oz, i % 4, exp_oz);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imode  = 1'b1;
        ivalid = 4'b1111;
        iready = 1'b0;
        step();
        checks++;
        if (oz !== 4'hA || ovalid !== 1'b1 || ogrant !== 2'd0) begin
            errors++;
            $display("FAIL bp_load: got oz=%h ovalid=%b ogrant=%0d want a 1 0", oz, ovalid, ogrant);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oready !== 4'b0000) begin
                errors++; $display("FAIL bp_oready[%0d]: got %b want 0000", i, oready);
            end
            step();
            checks++;
            if (oz !== 4'hA || ovalid !== 1'b1 || ogrant !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got oz=%h ovalid=%b ogrant=%0d want a 1 0",
                         i, oz, ovalid, ogrant);
            end
        end
        iready = 1'b1;
        #1;
        checks++;
        if (oready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready: got %b want %b", oready, 4'b0010);
        end
        step();
        checks++;
        if (oz !== 4'hB || ovalid !== 1'b1 || ogrant !== 2'd1) begin
            errors++;
            $display("FAIL bp_nobubble: got oz=%h ovalid=%b ogrant=%0d want b 1 1",
                     oz, ovalid, ogrant);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        imode  = 1'b1;
        ivalid = 4'b1111;
        iready = 1'b1;
        step();
        step();
        ivalid = 4'b1001;
        #1;
        checks++;
        if (oready !== 4'b1000) begin
            errors++; $display("FAIL sparse_ready3: got %b want %b", oready, 4'b1000);
        end
        step();
        checks++;
        if (ogrant !== 2'd3 || oz !== 4'hD) begin
            errors++; $display("FAIL sparse_grant3: got ogrant=%0d oz=%h want 3 d", ogrant, oz);
        end
        checks++;
        if (oready !== 4'b0001) begin
            errors++; $display("FAIL sparse_ready0: got %b want %b", oready, 4'b0001);
        end
        step();
        checks++;
        if (ogrant !== 2'd0 || oz !== 4'hA || ovalid !== 1'b1) begin
            errors++;
            $display("FAIL sparse_grant0: got ogrant=%0d oz=%h ovalid=%b want 0 a 1",
                     ogrant, oz, ovalid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imode  = 1'b1;
        ivalid = 4'b1111;
        iready = 1'b1;
        step();
        step();
        iready = 1'b0;
        step();
        checks++;
        if (ovalid !== 1'b1 || ogrant !== 2'd1 || oz !== 4'hB) begin
            errors++;
            $display("FAIL mid_hold: got ovalid=%b ogrant=%0d oz=%h want 1 1 b", ovalid, ogrant, oz);
        end
        irst   = 1'b1;
        iready = 1'b1;
        #1;
        checks++;
        if (oready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_ready: got %b want 0000", oready);
        end
        step();
        checks++;
        if (ovalid !== 1'b0 || oz !== 4'h0 || ogrant !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst_out: got ovalid=%b oz=%h ogrant=%0d want 0 0 0",
                     ovalid, oz, ogrant);
        end
        irst = 1'b0;
        #1;
        checks++;
        if (oready !== 4'b0001) begin
            errors++; $display("FAIL mid_ptr: got %b want %b", oready, 4'b0001);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        imode  = 1'b1;
        ivalid = 4'b1111;
        iready = 1'b1;
        step();
        imode = 1'b0;
        isel  = 2'd3;
        step();
        checks++;
        if (ogrant !== 2'd3 || oz !== 4'hD) begin
            errors++; $display("FAIL mode_fixed: got ogrant=%0d oz=%h want 3 d", ogrant, oz);
        end
        imode = 1'b1;
        #1;
        checks++;
        if (oready !== 4'b0010) begin
            errors++; $display("FAIL mode_ptr_kept: got %b want %b", oready, 4'b0010);
        end
        step();
        checks++;
        if (ogrant !== 2'd1 || oz !== 4'hB) begin
            errors++; $display("FAIL mode_rr_resume: got ogrant=%0d oz=%h want 1 b", ogrant, oz);
        end
    endtask

    initial begin
        irst   = 1'b1;
        ic     = 16'hDCBA;
        ivalid = '0;
        imode  = 1'b1;
        isel   = '0;
        iready = 1'b1;
        #2;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_mode_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer. It succeeds the combinational 4:1 nibble mux.
- Adds valid/ready handshakes on every input channel and on the output.
- Two selection modes: fixed (external select) and round-robin arbitration.
- One registered output stage. Sits between multiple producers and a single consumer, e.g. a shared display or bus port.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 4, data width per channel in bits.
- SELW, $clog2(NCH), select/grant index width (derived; not overridden).

Ports:
- iclk  input  1  clock; all state changes on rising edge.
- irst  input  1  synchronous reset, active-high.
- ic  input  NCH*W  channel data, flattened; channel k occupies bits [k*W +: W].
- ivalid  input  NCH  per-channel data valid.
- oready  output  NCH  per-channel accept; channel k transfers when ivalid[k] & oready[k].
- imode  input  1  0 = fixed select, 1 = round-robin.
- isel  input  SELW  channel index used in fixed mode.
- oz  output  W  registered output data.
- ovalid  output  1  oz holds a valid word.
- iready  input  1  downstream accept; output transfer when ovalid & iready.
- ogrant  output  SELW  index of the channel that supplied the current oz.

Behaviour:
- Reset: irst=1 at a rising edge gives oz=0, ovalid=0, ogrant=0, and round-robin pointer last=NCH-1 (first search starts at channel 0). oready is all zero while irst=1.
- Reset mid-operation discards any held word; no transfer completes in a reset cycle.
- load = ~ovalid | iready. The output stage can take a new word this cycle (empty, or draining simultaneously).
- Fixed mode (imode=0):
  - chosen = isel.
  - If isel >= NCH (non-power-of-2 NCH), no channel is chosen and oready=0.
- Round-robin mode (imode=1):
  - chosen = first k with ivalid[k]=1, searching last+1, last+2, ... wrapping modulo NCH.
  - If no ivalid is set, nothing is chosen.
- oready[k] = load & (k == chosen) & ~irst. oready is combinational from ivalid/imode/isel/iready/state and is never dependent on ivalid[k] for the fixed-mode channel. In round-robin mode it depends on ivalid by necessity.
- On an edge with ivalid[chosen] & oready[chosen]:
  - oz <= channel data, ogrant <= chosen, ovalid <= 1.
  - In round-robin mode, last <= chosen. In fixed mode, last is unchanged.
- On an edge with load=1 and no input transfer: ovalid <= 0 if the output drained. oz and ogrant hold their last values.
- Latency: 1 cycle from input handshake to ovalid. Throughput: 1 word/cycle when iready is held high.
- Backpressure: while ovalid=1 and iready=0, oz/ogrant/ovalid hold stable and all oready=0.
- Simultaneous drain and fill in the same cycle: the new word replaces the old one; ovalid stays 1 and there is no bubble.
- Mode or isel change takes effect in the same cycle's selection and never alters a word already held in oz. The round-robin pointer is preserved across fixed-mode periods.
- Fairness: with all channels continuously valid and iready=1, grants cycle 0,1,..,NCH-1,0,...
- At most one oready bit is high in any cycle (one-hot or zero).

Decomposition:
- Shared package: mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1; helper function for the wrapped search index.
- One sub-module, rr_arbiter: NCH-bit request vector plus last pointer in, chosen index plus found flag out. Purely combinational; the pointer register stays in stream_mux_rr.

Test Plan:
- Reset: hold irst 2 cycles with all ivalid=1 -> oready=0, ovalid=0, oz=0, ogrant=0. After release (RR, iready=1), the first grant is channel 0.
- Fixed mode, NCH=4, W=4, ic={4'hD,4'hC,4'hB,4'hA}, isel=2, ivalid=4'b0100 -> oready=4'b0100; next cycle oz=4'hC, ovalid=1, ogrant=2.
- Round-robin, all ivalid=1, iready=1 for 8 cycles -> ogrant sequence 0,1,2,3,0,1,2,3 with ovalid continuously 1.
- Backpressure: RR, ovalid=1 with oz=4'hA, iready=0 for 3 cycles -> oz=4'hA, ogrant=0 held, oready=0. iready=1 -> word drains and channel 1 is loaded the same cycle, no bubble.
- Sparse requests in RR with last=1, ivalid=4'b1001 -> grant 3, then grant 0; channels 1 and 2 are skipped.
- Reset mid-operation: ovalid=1 with iready=0, assert irst one cycle -> ovalid=0, word discarded, pointer back to NCH-1.
